// File: rtl/jtframe_dma_pkg.sv
// Shared types for the RAM-to-RAM DMA engine: FSM state encoding.
package jtframe_dma_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    COPY = 2'd2,
    DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/jtframe_dma_cnt.sv
// Loadable word counter for the DMA engine. Load clears the count and
// captures len-1 as the terminal value; tc_o flags the last word. The
// counter never needs to reach len, so AW bits suffice even for the
// largest transfer (2**AW-1 words).
module jtframe_dma_cnt #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [AW-1:0] len_i,
  output logic [AW-1:0] cnt_o,
  output logic          tc_o
);

  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] last_q, last_d;

  // Next count: load has priority over increment.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (load_i) begin
      cnt_d  = '0;
      last_d = len_i - AW'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + AW'(1);
    end
  end

  // Counter and terminal-value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == last_q);

endmodule

// File: rtl/jtframe_ram_dma.sv
// RAM-to-RAM DMA engine: copies len words from a source RAM (registered
// read, one cen of latency) to a destination RAM, one word per cen edge.
// Optional fill mode (macro JTFRAME_DMA_FILL_EN) writes fill_data instead
// of source data and skips the source read priming state.
//
// state | meaning
// IDLE  | waiting for start on a cen edge
// RD    | priming the source read at src_base
// COPY  | one destination write per cen edge
// DONE  | one-clock completion pulse
module jtframe_ram_dma
  import jtframe_dma_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW-1:0] len,
  input  logic          fill,
  input  logic [DW-1:0] fill_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_q,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_data,
  output logic          dst_we
);

  dma_state_e    state_q, state_d;
  logic [AW-1:0] src_base_q, dst_base_q;
  logic [AW-1:0] cnt;
  logic          tc;
  logic          load;
  logic          inc;
  logic          fill_sel;
  logic          fill_q;

  jtframe_dma_cnt #(.AW(AW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .inc_i  (inc),
    .len_i  (len),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );

`ifdef JTFRAME_DMA_FILL_EN
  assign fill_sel = fill;

  // Fill mode is captured with the other transfer parameters at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= 1'b0;
    else if (load) fill_q <= fill;
  end

  assign dst_data = fill_q ? fill_data : src_q;
`else
  assign fill_sel = 1'b0;
  assign fill_q   = 1'b0;
  assign dst_data = src_q;

  logic unused_fill;
  assign unused_fill = &{1'b0, fill, fill_data};
`endif

  // Next-state logic; cen gates every transition except leaving DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cen && start) begin
          load = 1'b1;
          if (len == '0)    state_d = DONE;
          else if (fill_sel) state_d = COPY;
          else              state_d = RD;
        end
      end
      RD: begin
        if (cen) state_d = COPY;
      end
      COPY: begin
        if (cen) begin
          if (tc) state_d = DONE;
          else    inc = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Base addresses are captured only when a transfer is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_base_q <= '0;
      dst_base_q <= '0;
    end else if (load) begin
      src_base_q <= src_base;
      dst_base_q <= dst_base;
    end
  end

  assign busy     = (state_q == RD) || (state_q == COPY);
  assign done     = (state_q == DONE);
  assign dst_we   = (state_q == COPY);
  assign dst_addr = dst_base_q + cnt;
  // In copy mode the source address runs one word ahead of the write.
  assign src_addr = ((state_q == COPY) && !fill_q) ? (src_base_q + cnt + AW'(1))
                                                   : src_base_q;

endmodule
